// File: rtl/sub4_operand_sequencer_pkg.sv
// Shared constants and state encoding for the 4-bit subtractor operand sequencer.
package sub4_pkg;

    localparam int NIBBLE_W         = 4;
    localparam int DEBOUNCE_DEFAULT = 500000;

    // Encodings are driven straight onto the board LEDs, so they are fixed.
    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_EXEC   = 2'd2,
        ST_SHOW   = 2'd3
    } state_t;

endpackage

// File: rtl/sub4_operand_sequencer_if.sv
// Operand/result bus between the sequencer (master) and the ripple subtractor (slave).
interface sub4_operand_sequencer_if;
    import sub4_pkg::*;

    logic [NIBBLE_W-1:0] sub_a;
    logic [NIBBLE_W-1:0] sub_b;
    logic                sub_bin;
    logic [NIBBLE_W-1:0] sub_d;
    logic                sub_bout;
    logic                sub_c3;

    modport master (output sub_a, sub_b, sub_bin, input sub_d, sub_bout, sub_c3);
    modport slave  (input sub_a, sub_b, sub_bin, output sub_d, sub_bout, sub_c3);

endinterface

// File: rtl/Subtrator4Bits.sv
// Combinational 4-bit ripple-borrow subtractor: D = A - B - Bin, C3 is the borrow into bit 3.
module Subtrator4Bits (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic [3:0] D,
    output logic       Bout,
    output logic       C3
);

    logic [4:0] w_br;

    // Full-subtractor chain, one stage per bit.
    always_comb begin
        w_br    = 5'b00000;
        w_br[0] = Bin;
        D       = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            D[i]      = A[i] ^ B[i] ^ w_br[i];
            w_br[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_br[i]);
        end
    end

    assign Bout = w_br[4];
    assign C3   = w_br[3];

endmodule

// File: rtl/sub4_operand_sequencer_key_debounce_pulse.sv
// Synchronises and debounces one raw pushbutton, emitting a single-cycle pulse per accepted press.
module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    // Synchroniser, run-length counter on the new level, and rising-edge pulse on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_pulse  <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign key_pulse = r_pulse;

endmodule

// File: rtl/sub4_operand_sequencer.sv
// Collects A then B from the switches on NEXT presses, drives the subtractor and latches its result.
module sub4_operand_sequencer
    import sub4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NIBBLE_W-1:0]   sw_data,
    input  logic                  key_next_raw,
    input  logic                  key_clear_raw,
    sub4_operand_sequencer_if.master sub_if,
    output logic [NIBBLE_W-1:0]   result,
    output logic                  flag_borrow,
    output logic                  flag_zero,
    output logic                  flag_ovf,
    output logic                  result_valid,
    output logic [1:0]            state
);

    logic w_next_pulse;
    logic w_clear_pulse;

    key_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_next_raw),
        .key_pulse (w_next_pulse)
    );

    key_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_clear_raw),
        .key_pulse (w_clear_pulse)
    );

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load_a;
    logic                w_load_b;
    logic                w_capture;
    logic                w_clear;
    logic                w_drop_valid;
    logic [NIBBLE_W-1:0] r_a;
    logic [NIBBLE_W-1:0] r_b;
    logic [NIBBLE_W-1:0] r_result;
    logic                r_borrow;
    logic                r_zero;
    logic                r_ovf;
    logic                r_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and register-update strobes; CLEAR overrides any NEXT in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_capture    = 1'b0;
        w_clear      = 1'b0;
        w_drop_valid = 1'b0;
        if (w_clear_pulse) begin
            w_clear     = 1'b1;
            w_state_nxt = ST_LOAD_A;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    if (w_next_pulse) begin
                        w_load_a    = 1'b1;
                        w_state_nxt = ST_LOAD_B;
                    end else begin
                        w_state_nxt = ST_LOAD_A;
                    end
                end
                ST_LOAD_B: begin
                    if (w_next_pulse) begin
                        w_load_b    = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_LOAD_B;
                    end
                end
                ST_EXEC: begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SHOW;
                end
                ST_SHOW: begin
                    if (w_next_pulse) begin
                        w_drop_valid = 1'b1;
                        w_state_nxt  = ST_LOAD_A;
                    end else begin
                        w_state_nxt = ST_SHOW;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOAD_A;
                end
            endcase
        end
    end

    // Operand and result registers; the subtractor output has settled by the EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_result <= 4'd0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_load_a) begin
                r_a <= sw_data;
            end
            if (w_load_b) begin
                r_b <= sw_data;
            end
            if (w_capture) begin
                r_result <= sub_if.sub_d;
                r_borrow <= sub_if.sub_bout;
                r_zero   <= (sub_if.sub_d == 4'd0);
                r_ovf    <= sub_if.sub_c3 ^ sub_if.sub_bout;
                r_valid  <= 1'b1;
            end
            if (w_drop_valid) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sub_if.sub_a   = r_a;
    assign sub_if.sub_b   = r_b;
    assign sub_if.sub_bin = 1'b0;
    assign result         = r_result;
    assign flag_borrow    = r_borrow;
    assign flag_zero      = r_zero;
    assign flag_ovf       = r_ovf;
    assign result_valid   = r_valid;
    assign state          = r_state;

endmodule
